// File: rtl/gmii_tx_sched.sv
// gmii_tx_sched: round-robin GMII TX scheduler with preamble/SFD insertion and inter-frame gap.
// Define GMII_TX_SCHED_UNDERRUN_ERR_EN to assert TX_ERR on underrun cycles.
module gmii_tx_sched #(
  parameter int N_REQ     = 2,
  parameter int IFG_BYTES = 12
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               TX_D,
  output logic                     TX_EN,
  output logic                     TX_ERR,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int GW = $clog2(N_REQ);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IFG} state_t;
  state_t r_state, w_state_nxt;
  logic [2:0]    r_pre_cnt;
  logic [5:0]    r_ifg_cnt;
  logic [GW-1:0] r_rr, r_grant, w_win, w_idx, w_rr_nxt;
  logic          w_any, w_arb, w_xfer, w_valid, w_last, w_hs;
  logic [7:0]    w_data, r_tx_d;
  logic          r_tx_en, r_frame_done;

  // Scan downward so the index closest to rr is written last and wins.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = GW'((int'(r_rr) + i) % N_REQ);
      if (req_valid[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_rr_nxt = (w_win == GW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_xfer   = (r_state == SFD) || (r_state == DATA);
  assign w_valid  = req_valid[r_grant];
  assign w_last   = req_last[r_grant];
  assign w_data   = req_data[8*r_grant +: 8];
  assign w_hs     = w_xfer && w_valid;
  assign w_arb    = (r_state == IDLE) || (r_state == IFG && r_ifg_cnt == 6'(IFG_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      w_state_nxt = w_any ? PRE : IDLE;
      PRE:       w_state_nxt = (r_pre_cnt == 3'd6) ? SFD : PRE;
      SFD, DATA: w_state_nxt = (w_hs && w_last) ? IFG : DATA;
      IFG:       w_state_nxt = w_arb ? (w_any ? PRE : IDLE) : IFG;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_pre_cnt    <= '0;
      r_ifg_cnt    <= '0;
      r_rr         <= '0;
      r_grant      <= '0;
      r_tx_d       <= '0;
      r_tx_en      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pre_cnt    <= (r_state == PRE) ? r_pre_cnt + 3'd1 : 3'd0;
      r_ifg_cnt    <= (r_state == IFG) ? r_ifg_cnt + 6'd1 : 6'd0;
      r_frame_done <= w_hs && w_last;
      r_tx_en      <= w_xfer || r_state == PRE || w_state_nxt == PRE;
      // An empty source mid-frame still keeps TX_EN high, sending 0x00 filler.
      r_tx_d       <= w_hs ? w_data : (w_state_nxt == SFD) ? 8'hD5 : (w_state_nxt == PRE) ? 8'h55 : 8'h00;
      if (w_arb && w_any) begin
        r_grant <= w_win;
        r_rr    <= w_rr_nxt;
      end
    end
  end

`ifdef GMII_TX_SCHED_UNDERRUN_ERR_EN
  logic r_tx_err;
  always_ff @(posedge CLK) begin
    if (!RST) r_tx_err <= 1'b0;
    else      r_tx_err <= w_xfer && !w_valid;
  end
  assign TX_ERR = r_tx_err;
`else
  assign TX_ERR = 1'b0;
`endif

  assign req_ready  = w_xfer ? N_REQ'(1) << r_grant : '0;
  assign TX_D       = r_tx_d;
  assign TX_EN      = r_tx_en;
  assign grant_id   = r_grant;
  assign busy       = r_state != IDLE;
  assign frame_done = r_frame_done;
endmodule

// File: doc/gmii_tx_sched.md
# gmii_tx_sched

Round-robin transmit scheduler that shares the single GMII transmit port of `mac_phy` between `N_REQ` frame sources. The block grants one source at a time and emits the 7-byte preamble and SFD. It then streams the granted source's bytes onto `TX_D`/`TX_EN` and enforces the inter-frame gap before the next grant. It sits between the per-source TX FIFOs and the GMII TX pins in the 125 MHz TX clock domain.

## Interface
- `N_REQ`, 2 — number of requesters, 2..8.
- `IFG_BYTES`, 12 — minimum `TX_EN`-low cycles between frames, 2..63.
- `CLK` in 1 — 125 MHz GMII TX clock; sole clock.
- `RST` in 1 — synchronous, active-low reset.
- `req_valid` in N_REQ — per-source byte valid.
- `req_data` in 8*N_REQ — per-source byte; source i uses bits [8i+7:8i].
- `req_last` in N_REQ — marks the final byte of a frame. Frames already include FCS.
- `req_ready` out N_REQ — one-hot byte accept; zero outside SFD/DATA.
- `TX_D` out 8 — GMII transmit data, registered.
- `TX_EN` out 1 — GMII transmit enable, registered.
- `TX_ERR` out 1 — GMII transmit error, registered.
- `grant_id` out $clog2(N_REQ) — index of the current or last granted source.
- `busy` out 1 — high in any state other than IDLE.
- `frame_done` out 1 — one-cycle pulse on the cycle the last byte is shown on `TX_D`.

## Operation
- States: IDLE, PRE, SFD, DATA, IFG.
- **IDLE**
  - A source counts as requesting when its `req_valid` is high.
  - If any source requests, the block grants the first requesting index at or after the round-robin pointer `rr`, searching upward with modulo wrap.
  - On grant: `grant_id` ← winner, `rr` ← winner+1 mod N_REQ, go to PRE.
- **PRE**: runs for 7 cycles, then goes to SFD. A 3-bit counter tracks the cycles.
- **SFD**: runs for 1 cycle, then goes to DATA. `req_ready[grant_id]`=1 in this state.
- **DATA**
  - `req_ready[grant_id]`=1.
  - Each handshake (valid & ready) loads the byte into the `TX_D` register.
  - A handshake with `req_last` goes to IFG, and `req_ready` drops in the following cycle.
- **IFG**: counts `IFG_BYTES` cycles with `TX_EN`=0. In the final IFG cycle it arbitrates exactly as IDLE does. If there is no requester, it goes to IDLE.
- **Underrun**: in DATA with `req_valid[grant_id]`=0, the next output cycle has `TX_EN`=1 and `TX_D`=0x00. `TX_ERR` follows Configuration. The frame is not aborted; the state stays DATA.
- Non-granted sources never see `req_ready`, and their requests stay pending.
- `req_ready` is combinational from state and `grant_id` only. It has no combinational path from `req_valid`.

## Timing
- **Reset**: while `RST`=0 at an edge, the block forces:
  - state IDLE
  - `TX_D`=0x00, `TX_EN`=0, `TX_ERR`=0
  - `rr`=0, `grant_id`=0
  - `busy`=0, `frame_done`=0
  - `req_ready`=0 from the cycle after that edge
- **Reset mid-frame**: `TX_EN` drops the cycle after the reset edge. The interrupted source's frame is abandoned; the source flushes it itself.
- **Grant latency**: a request seen in IDLE at cycle c gives:
  - `TX_EN`=1 with `TX_D`=0x55 in cycles c+1..c+7
  - `TX_D`=0xD5 in cycle c+8
  - `req_ready` high from cycle c+8
  - the first accepted byte on `TX_D` in cycle c+9
- **Data latency**: a byte accepted in cycle k appears on `TX_D` in cycle k+1.
- **Frame end**: the last byte is accepted in cycle k.
  - `TX_D` shows it in k+1, with `frame_done`=1.
  - `TX_EN`=0 in k+2..k+1+`IFG_BYTES`.
  - If a request is pending by cycle k+1+`IFG_BYTES`, the next preamble starts at k+2+`IFG_BYTES`. The gap is never shorter than `IFG_BYTES`.
- **Simultaneous requests**: exactly one grant is issued, chosen by `rr`. With all N sources requesting continuously, grants go in the order rr, rr+1, ….

## Configuration
- `GMII_TX_SCHED_UNDERRUN_ERR_EN`
  - Defined: each underrun output cycle drives `TX_ERR`=1 alongside `TX_D`=0x00, `TX_EN`=1.
  - Undefined: `TX_ERR` is constant 0 and underrun cycles carry only `TX_D`=0x00.

## Test plan
- **Single frame**: source 0 sends a 64-byte frame at cycle 10.
  - `TX_D` shows 0x55 ×7 in cycles 11–17, then 0xD5 in cycle 18.
  - Payload appears in cycles 19–82.
  - `frame_done` pulses in cycle 82 and `TX_EN` is low from cycle 83.
- **Contention**: sources 0 and 1 request in the same cycle after reset.
  - Source 0 transmits first and source 1 second.
  - `TX_EN` is low for exactly 12 cycles between the two frames.
  - `grant_id` reads 0 then 1.
- **Round-robin fairness**: with N_REQ=4 and all sources requesting continuously for 8 frames, the grant order is 0,1,2,3,0,1,2,3.
- **Underrun**: `req_valid` is dropped for 3 cycles mid-payload.
  - `TX_D` shows 0x00 ×3 with `TX_EN`=1.
  - `TX_ERR`=1 on those cycles only when `GMII_TX_SCHED_UNDERRUN_ERR_EN` is defined, else 0.
  - The total frame length grows by 3.
- **Reset mid-frame**: `RST`=0 is applied during DATA.
  - The next cycle shows `TX_EN`=0, `TX_ERR`=0, `req_ready`=0, `busy`=0.
  - After release, a new request from source 1 gets a preamble in the cycle after the request.
- **Single-byte frame**: a frame with `req_last` on the first byte.
  - One data cycle follows the SFD, then an IFG of 12 cycles.
  - `req_ready` is low in the cycle after the handshake.
